stf_autocorr_detect: RTL and testbench

Packet detector and coarse-CFO correlator for the 802.11a receiver, sitting directly upstream of the frequency-offset estimation/compensation stage. It computes the 16-sample delayed autocorrelation P and the windowed energy R of the short training field. It raises `ena` once |P| stays above a fraction of R for a plateau of samples. `P_Re`/`P_Im`, `ena`, `dat_out` and `stb_out` feed the compensator's `P_Re`, `P_Im`, `ena`, `dat_in` and `stb_in`.

---
 rtl/ofdm_rx_pkg.sv | 30 +++
 rtl/cplx_delay16.sv | 29 ++
 rtl/stf_autocorr_detect.sv | 199 +++++++++++++++++++
 tb/tb_stf_autocorr_detect.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ofdm_rx_pkg.sv
// Shared widths, product slicing and detector state encoding for the OFDM receive path.
package ofdm_rx_pkg;

   localparam int SAMP_W  = 16;
   localparam int P_W     = 23;
   localparam int TERM_HI = 31;
   localparam int TERM_LO = 13;
   localparam int TERM_W  = TERM_HI - TERM_LO + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_COUNT = 2'd1,
      ST_LOCK  = 2'd2
   } det_state_e;

   // Cheap |z| estimate: max(|re|,|im|) + min(|re|,|im|)/2.
   function automatic logic [P_W:0] cmag(input logic signed [P_W-1:0] re,
                                         input logic signed [P_W-1:0] im);
      logic [P_W-1:0] ar;
      logic [P_W-1:0] ai;
      logic [P_W-1:0] mx;
      logic [P_W-1:0] mn;
      ar = re[P_W-1] ? P_W'(-re) : P_W'(re);
      ai = im[P_W-1] ? P_W'(-im) : P_W'(im);
      mx = (ar > ai) ? ar : ai;
      mn = (ar > ai) ? ai : ar;
      return {1'b0, mx} + {2'b00, mn[P_W-1:1]};
   endfunction

endpackage

// File: rtl/cplx_delay16.sv
// 16-deep shift delay line; advances only when en is high, synchronous clear.
module cplx_delay16 #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   logic [W-1:0] tap_q [16];

   generate
      for (genvar gi = 0; gi < 16; gi++) begin : g_tap
         always_ff @(posedge clk) begin
            if (clr) begin
               tap_q[gi] <= '0;
            end else if (en) begin
               if (gi == 0) tap_q[gi] <= din;
               else         tap_q[gi] <= tap_q[(gi == 0) ? 0 : gi-1];
            end
         end
      end
   endgenerate

   assign dout = tap_q[15];

endmodule

// File: rtl/stf_autocorr_detect.sv
// Short-training-field detector: 16-lag autocorrelation P, windowed energy R,
// plateau qualification and lock/release FSM, 3-stage ce-gated pipeline.
module stf_autocorr_detect
   import ofdm_rx_pkg::*;
#(
   parameter int unsigned     PLATEAU_LEN = 48,
   parameter int unsigned     DROP_LEN    = 32,
   parameter logic [P_W-1:0]  E_MIN       = 23'd2048,
   parameter int unsigned     THR_NUM     = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ce,
   input  logic [31:0]           dat_in,
   input  logic                  stb_in,
   output logic [31:0]           dat_out,
   output logic                  stb_out,
   output logic signed [P_W-1:0] P_Re,
   output logic signed [P_W-1:0] P_Im,
   output logic                  ena
);

   localparam int CNT_W  = $clog2(PLATEAU_LEN + 1);
   localparam int DROP_W = $clog2(DROP_LEN + 1);

   // ---------------- S1: products against the 16-sample-old history
   logic [31:0]              xd16;
   logic signed [SAMP_W-1:0] xr, xi, dr, di;
   logic signed [31:0]       p_rr, p_ii, p_ir, p_ri, p_dd, p_ee;
   logic signed [32:0]       c_re_full, c_im_full, e_full;
   logic [TERM_W-1:0]        c_re_t, c_im_t, e_t;

   cplx_delay16 #(.W(32)) u_samp_dly (
      .clk  (clk),
      .clr  (rst),
      .en   (ce & stb_in),
      .din  (dat_in),
      .dout (xd16)
   );

   assign xr = $signed(dat_in[15:0]);
   assign xi = $signed(dat_in[31:16]);
   assign dr = $signed(xd16[15:0]);
   assign di = $signed(xd16[31:16]);

   assign p_rr = 32'(xr) * 32'(dr);
   assign p_ii = 32'(xi) * 32'(di);
   assign p_ir = 32'(xi) * 32'(dr);
   assign p_ri = 32'(xr) * 32'(di);
   assign p_dd = 32'(dr) * 32'(dr);
   assign p_ee = 32'(di) * 32'(di);

   assign c_re_full = 33'(p_rr) + 33'(p_ii);
   assign c_im_full = 33'(p_ir) - 33'(p_ri);
   assign e_full    = 33'(p_dd) + 33'(p_ee);

   // Bit 32 is intentionally dropped: the term is bits [31:13].
   assign c_re_t = TERM_W'(c_re_full >>> TERM_LO);
   assign c_im_t = TERM_W'(c_im_full >>> TERM_LO);
   assign e_t    = TERM_W'(e_full >>> TERM_LO);

   logic              stb1_q;
   logic [31:0]       x1_q;
   logic [TERM_W-1:0] cre1_q, cim1_q, e1_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stb1_q <= 1'b0;
         x1_q   <= '0;
         cre1_q <= '0;
         cim1_q <= '0;
         e1_q   <= '0;
      end else if (ce) begin
         stb1_q <= stb_in;
         if (stb_in) begin
            x1_q   <= dat_in;
            cre1_q <= c_re_t;
            cim1_q <= c_im_t;
            e1_q   <= e_t;
         end
      end
   end

   // ---------------- S2: moving sums via the term delay line
   logic [3*TERM_W-1:0]   term_old;
   logic [TERM_W-1:0]     cre_old, cim_old, e_old;
   logic signed [P_W-1:0] pre_q, pim_q, pre_d, pim_d;
   logic [P_W-1:0]        r_q, r_d;
   logic                  stb2_q;
   logic [31:0]           x2_q;

   cplx_delay16 #(.W(3*TERM_W)) u_term_dly (
      .clk  (clk),
      .clr  (rst),
      .en   (ce & stb1_q),
      .din  ({cre1_q, cim1_q, e1_q}),
      .dout (term_old)
   );

   assign {cre_old, cim_old, e_old} = term_old;

   assign pre_d = pre_q + {{(P_W-TERM_W){cre1_q[TERM_W-1]}}, cre1_q}
                        - {{(P_W-TERM_W){cre_old[TERM_W-1]}}, cre_old};
   assign pim_d = pim_q + {{(P_W-TERM_W){cim1_q[TERM_W-1]}}, cim1_q}
                        - {{(P_W-TERM_W){cim_old[TERM_W-1]}}, cim_old};
   assign r_d   = r_q + {{(P_W-TERM_W){1'b0}}, e1_q} - {{(P_W-TERM_W){1'b0}}, e_old};

   always_ff @(posedge clk) begin
      if (rst) begin
         stb2_q <= 1'b0;
         x2_q   <= '0;
         pre_q  <= '0;
         pim_q  <= '0;
         r_q    <= '0;
      end else if (ce) begin
         stb2_q <= stb1_q;
         if (stb1_q) begin
            x2_q  <= x1_q;
            pre_q <= pre_d;
            pim_q <= pim_d;
            r_q   <= r_d;
         end
      end
   end

   // ---------------- S3: qualification, FSM and output register
   logic [P_W:0]   mag;
   logic [P_W+2:0] thr_r;
   logic           e_ok, qual;

   assign mag   = cmag(pre_q, pim_q);
   assign thr_r = (P_W+3)'(THR_NUM) * (P_W+3)'(r_q);
   assign e_ok  = (r_q >= E_MIN);
   assign qual  = ({1'b0, mag, 2'b00} > {1'b0, thr_r}) && e_ok;

   det_state_e        state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [DROP_W-1:0] drop_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         drop_q  <= '0;
         ena     <= 1'b0;
         stb_out <= 1'b0;
         dat_out <= '0;
         P_Re    <= '0;
         P_Im    <= '0;
      end else if (ce) begin
         stb_out <= stb2_q;
         if (stb2_q) begin
            dat_out <= x2_q;
            P_Re    <= pre_q;
            P_Im    <= pim_q;
            case (state_q)
               ST_IDLE: begin
                  if (qual) begin
                     state_q <= ST_COUNT;
                     cnt_q   <= CNT_W'(1);
                  end
               end
               ST_COUNT: begin
                  if (!qual) begin
                     state_q <= ST_IDLE;
                     cnt_q   <= '0;
                  end else if (cnt_q == CNT_W'(PLATEAU_LEN - 1)) begin
                     state_q <= ST_LOCK;
                     cnt_q   <= '0;
                     drop_q  <= '0;
                     ena     <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
               ST_LOCK: begin
                  // Only energy matters once locked; the ratio test is ignored.
                  if (e_ok) begin
                     drop_q <= '0;
                  end else if (drop_q == DROP_W'(DROP_LEN - 1)) begin
                     state_q <= ST_IDLE;
                     drop_q  <= '0;
                     ena     <= 1'b0;
                  end else begin
                     drop_q <= drop_q + DROP_W'(1);
                  end
               end
               default: begin
                  state_q <= ST_IDLE;
                  cnt_q   <= '0;
                  drop_q  <= '0;
                  ena     <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_stf_autocorr_detect.sv
// Directed STF scenarios plus randomized tone/noise traffic against a window-sum reference model.
module tb_stf_autocorr_detect;

   logic               clk = 1'b0;
   logic               rst, ce, stb_in;
   logic [31:0]        dat_in;
   logic [31:0]        dat_out;
   logic               stb_out, ena;
   logic signed [22:0] P_Re, P_Im;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   stf_autocorr_detect dut (
      .clk     (clk),
      .rst     (rst),
      .ce      (ce),
      .dat_in  (dat_in),
      .stb_in  (stb_in),
      .dat_out (dat_out),
      .stb_out (stb_out),
      .P_Re    (P_Re),
      .P_Im    (P_Im),
      .ena     (ena)
   );

   typedef struct {
      logic        v;
      logic [31:0] dat;
      longint      pre;
      longint      pim;
      logic        ena;
   } rec_t;

   // Reference state: every sample since reset and its derived terms.
   logic [31:0] hist[$];
   longint      tre[$], tim[$], te[$];
   int          run, low;
   bit          locked;
   rec_t        s1, s2;
   logic        exp_stb, exp_ena;
   logic [31:0] exp_dat;
   longint      exp_pre, exp_pim;

   int     samp_out, rise_cnt, fall_cnt, rise_idx;
   longint rise_pre, rise_pim;
   logic   ena_prev;

   task automatic check_val(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic longint slice_s(input longint v);
      longint t;
      t = (v >>> 13) & 64'h7FFFF;
      if (t >= 64'sd262144) t = t - 64'sd524288;
      return t;
   endfunction

   function automatic longint slice_u(input longint v);
      return (v >>> 13) & 64'h7FFFF;
   endfunction

   function automatic rec_t idle_rec();
      rec_t r;
      r.v = 1'b0; r.dat = 32'd0; r.pre = 0; r.pim = 0; r.ena = 1'b0;
      return r;
   endfunction

   task automatic model_reset();
      hist.delete(); tre.delete(); tim.delete(); te.delete();
      run = 0; low = 0; locked = 0;
      s1 = idle_rec(); s2 = idle_rec();
      exp_stb = 0; exp_ena = 0; exp_dat = 0; exp_pre = 0; exp_pim = 0;
   endtask

   task automatic model_push(input logic [31:0] d, output rec_t o);
      int          k;
      logic [31:0] h;
      longint      xr, xi, hr, hi, sp, si, sr, ar, ai, mx, mn, mag;
      bit          qual;
      k  = hist.size();
      h  = (k >= 16) ? hist[k-16] : 32'd0;
      xr = longint'($signed(d[15:0]));
      xi = longint'($signed(d[31:16]));
      hr = longint'($signed(h[15:0]));
      hi = longint'($signed(h[31:16]));
      hist.push_back(d);
      tre.push_back(slice_s(xr*hr + xi*hi));
      tim.push_back(slice_s(xi*hr - xr*hi));
      te.push_back(slice_u(hr*hr + hi*hi));
      sp = 0; si = 0; sr = 0;
      for (int j = (k >= 15) ? k-15 : 0; j <= k; j++) begin
         sp += tre[j]; si += tim[j]; sr += te[j];
      end
      ar  = (sp < 0) ? -sp : sp;
      ai  = (si < 0) ? -si : si;
      mx  = (ar > ai) ? ar : ai;
      mn  = (ar > ai) ? ai : ar;
      mag = mx + mn / 2;
      qual = (4*mag > 3*sr) && (sr >= 2048);
      if (!locked) begin
         run = qual ? run + 1 : 0;
         if (run == 48) begin locked = 1; run = 0; end
      end else begin
         low = (sr < 2048) ? low + 1 : 0;
         if (low == 32) begin locked = 0; low = 0; end
      end
      o.v = 1'b1; o.dat = d; o.pre = sp; o.pim = si; o.ena = locked;
   endtask

   task automatic step(input logic r, input logic c, input logic s, input logic [31:0] d);
      rst = r; ce = c; stb_in = s; dat_in = d;
      @(posedge clk);
      if (r) begin
         model_reset();
      end else if (c) begin
         exp_stb = s2.v;
         if (s2.v) begin
            exp_dat = s2.dat; exp_pre = s2.pre; exp_pim = s2.pim; exp_ena = s2.ena;
         end
         s2 = s1;
         if (s) model_push(d, s1);
         else   s1 = idle_rec();
      end
      #1;
      check_val("stb_out", longint'(stb_out), longint'(exp_stb));
      check_val("dat_out", longint'(dat_out), longint'(exp_dat));
      check_val("P_Re",    longint'(P_Re),    exp_pre);
      check_val("P_Im",    longint'(P_Im),    exp_pim);
      check_val("ena",     longint'(ena),     longint'(exp_ena));
      if (r) begin
         samp_out = 0;
      end else begin
         if (stb_out && c) samp_out++;
         if (ena && !ena_prev) begin
            rise_cnt++; rise_idx = samp_out;
            rise_pre = longint'(P_Re); rise_pim = longint'(P_Im);
         end
         if (!ena && ena_prev) fall_cnt++;
      end
      ena_prev = ena;
   endtask

   task automatic do_reset();
      step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      step(1'b1, 1'b1, 1'b0, 32'd0);
      rise_cnt = 0; fall_cnt = 0; rise_idx = -1; rise_pre = 0; rise_pim = 0;
   endtask

   task automatic send(input logic [31:0] d);
      step(1'b0, 1'b1, 1'b1, d);
   endtask

   function automatic logic [15:0] sat16(input real v);
      int t;
      t = $rtoi(v >= 0.0 ? v + 0.5 : v - 0.5);
      if (t > 32767)  t = 32767;
      if (t < -32768) t = -32768;
      return 16'(t);
   endfunction

   function automatic logic [31:0] tone(input real amp, input real w, input int n);
      return {sat16(amp * $sin(w * n)), sat16(amp * $cos(w * n))};
   endfunction

   localparam real PI = 3.14159265358979;

   initial begin
      rst = 1'b1; ce = 1'b0; stb_in = 1'b0; dat_in = 32'd0; ena_prev = 1'b0;
      samp_out = 0;
      model_reset();

      // Reset state, then a mid-stream reset with random traffic beforehand.
      do_reset();
      for (int i = 0; i < 20; i++) send($urandom);
      do_reset();
      check_val("rst_ena", longint'(ena), 0);

      // Constant tone: lock completes on sample 63.
      for (int i = 0; i < 80; i++) send({16'd0, 16'd8192});
      check_val("tone_rise_cnt", rise_cnt, 1);
      check_val("tone_rise_idx", rise_idx, 64);
      check_val("tone_rise_pre", rise_pre, 131072);
      check_val("tone_rise_pim", rise_pim, 0);
      for (int i = 0; i < 100; i++) send(32'd0);
      check_val("release_fall", fall_cnt, 1);

      // Phase-rotating tone: c points at -1.
      do_reset();
      for (int i = 0; i < 80; i++) send(tone(8192.0, PI / 16.0, i));
      check_val("ptone_rise_idx", rise_idx, 64);
      check_val("ptone_pre_tol", longint'(rise_pre >= -131088 && rise_pre <= -131056), 1);
      check_val("ptone_pim_tol", longint'(rise_pim >= -16 && rise_pim <= 16), 1);

      // Too little energy to ever qualify.
      do_reset();
      for (int i = 0; i < 200; i++) send({16'd0, 16'd256});
      check_val("lowamp_no_lock", rise_cnt, 0);

      // Interrupted plateau must restart.
      do_reset();
      for (int i = 0; i < 40; i++) send({16'd0, 16'd8192});
      for (int i = 0; i < 8; i++)  send(32'd0);
      for (int i = 0; i < 100; i++) send({16'd0, 16'd8192});
      check_val("gap_rise_cnt", rise_cnt, 1);
      check_val("gap_rise_late", longint'(rise_idx > 88), 1);

      // ce low for 5 cycles mid-stream: nothing lost, nothing moves.
      do_reset();
      for (int i = 0; i < 30; i++) send(tone(8192.0, PI / 8.0, i));
      for (int i = 0; i < 5; i++)  step(1'b0, 1'b0, 1'b1, $urandom);
      for (int i = 30; i < 80; i++) send(tone(8192.0, PI / 8.0, i));
      check_val("ce_rise_idx", rise_idx, 64);

      // Randomized segments: tone + noise, sparse strobes and ce.
      for (int seg = 0; seg < 6; seg++) begin
         real amp, w;
         int  na, n;
         logic c, s;
         logic [31:0] d;
         do_reset();
         case ($urandom_range(0, 3))
            0: amp = 256.0;
            1: amp = 4000.0;
            2: amp = 8192.0;
            default: amp = 20000.0;
         endcase
         w  = PI * real'($urandom_range(0, 31)) / 16.0;
         na = $urandom_range(0, 3000);
         n  = 0;
         for (int i = 0; i < 300; i++) begin
            c = ($urandom_range(0, 9) != 0);
            s = ($urandom_range(0, 3) != 0);
            d = tone(amp, w, n);
            d[15:0]  = d[15:0]  + 16'($urandom_range(0, 2*na) - na);
            d[31:16] = d[31:16] + 16'($urandom_range(0, 2*na) - na);
            if (i > 200 && i < 240) d = 32'd0;
            step(1'b0, c, s, d);
            if (c && s) n++;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
